parallel_mul: RTL and testbench

// - Free-running unsigned 1024x1024 -> 2048-bit multiplier for the large-number datapath.
// - Repeatedly samples In1/In2, computes the exact product over a fixed number of cycles and

---
 rtl/parallel_mul_pkg.sv | 23 ++
 rtl/parallel_mul_limb_row.sv | 34 +++
 rtl/parallel_mul.sv | 112 +++++++++++
 tb/tb_parallel_mul.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/parallel_mul_pkg.sv
// Shared definitions for the parallel_mul large-number multiplier.
//   WIDTH   : operand width (product is 2*WIDTH bits)
//   LIMB    : slice width of the multiplier operand consumed per RUN cycle
//   LIMBS   : number of slices, equal to the number of RUN cycles
//   IDX_W   : width of the slice index counter
//   SHIFT_W : width of a bit offset into the 2*WIDTH accumulator
//   state_e : controller states CAPTURE -> RUN -> DONE
package pm_pkg;

  localparam int WIDTH   = 1024;
  localparam int LIMB    = 64;
  localparam int LIMBS   = WIDTH / LIMB;
  // A single-limb configuration would give $clog2(1) = 0; keep one bit minimum.
  localparam int IDX_W   = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam int SHIFT_W = $clog2(2 * WIDTH);

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/parallel_mul_limb_row.sv
// mul_limb_row: combinational WIDTH x LIMB -> (WIDTH+LIMB)-bit unsigned product.
// Ports:
//   a_i   [WIDTH-1:0]       full-width multiplicand
//   b_i   [LIMB-1:0]        one limb of the multiplier
//   row_o [WIDTH+LIMB-1:0]  exact product a_i * b_i
// The multiplicand is split into LIMBS limbs; each limb is multiplied by b_i
// in its own LIMB x LIMB multiplier and the 2*LIMB-bit partial products are
// summed at their limb offsets with full-width adds, so carries out of one
// limb position ripple into the next.
module mul_limb_row
  import pm_pkg::*;
(
  input  logic [WIDTH-1:0]      a_i,
  input  logic [LIMB-1:0]       b_i,
  output logic [WIDTH+LIMB-1:0] row_o
);

  logic [2*LIMB-1:0] pp [LIMBS];

  for (genvar g = 0; g < LIMBS; g++) begin : g_limb_mul
    assign pp[g] = (2*LIMB)'(a_i[g*LIMB +: LIMB]) * (2*LIMB)'(b_i);
  end

  // Overlapping partial products: pp[i] spans bits [i*LIMB, i*LIMB+2*LIMB),
  // so neighbouring terms overlap by one limb. The total is bounded by
  // (2^WIDTH-1)*(2^LIMB-1) and therefore fits WIDTH+LIMB bits exactly.
  always_comb begin
    row_o = '0;
    for (int i = 0; i < LIMBS; i++) begin
      row_o = row_o + ((WIDTH+LIMB)'(pp[i]) << (i * LIMB));
    end
  end

endmodule

// File: rtl/parallel_mul.sv
// parallel_mul: free-running unsigned WIDTH x WIDTH -> 2*WIDTH multiplier.
// Ports:
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   In1 [WIDTH-1:0]    multiplicand, sampled in CAPTURE, no handshake
//   In2 [WIDTH-1:0]    multiplier, sampled in CAPTURE, no handshake
//   Out [2*WIDTH-1:0]  last completed product, updated only in DONE
//   dbg_state_o [1:0]  current controller state (state_e encoding)
// Operation loops forever: CAPTURE (1 cycle) latches the operands, RUN
// (LIMBS cycles) accumulates one shifted row per multiplier limb, DONE
// (1 cycle) publishes the accumulator. Period is LIMBS+2 cycles.
// There is no valid/ready handshake: the inputs are treated as level
// signals, and Out is always a complete, registered product.
module parallel_mul
  import pm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [WIDTH-1:0]     In1,
  input  logic [WIDTH-1:0]     In2,
  output logic [2*WIDTH-1:0]   Out,
  output logic [1:0]           dbg_state_o
);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic [WIDTH-1:0]     a_q,     a_d;
  logic [WIDTH-1:0]     b_q,     b_d;
  logic [2*WIDTH-1:0]   acc_q,   acc_d;
  logic [2*WIDTH-1:0]   out_q,   out_d;

  logic [LIMB-1:0]       b_slice;
  logic [WIDTH+LIMB-1:0] row;
  logic [SHIFT_W-1:0]    shamt;
  logic [2*WIDTH-1:0]    row_shifted;

  // Limb select as an explicit mux over idx so the index never has to be
  // widened into a variable part-select.
  always_comb begin
    b_slice = '0;
    for (int i = 0; i < LIMBS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        b_slice = b_q[i*LIMB +: LIMB];
      end
    end
  end

  mul_limb_row u_row (
    .a_i   (a_q),
    .b_i   (b_slice),
    .row_o (row)
  );

  assign shamt       = SHIFT_W'(idx_q) * SHIFT_W'(LIMB);
  assign row_shifted = (2*WIDTH)'(row) << shamt;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    out_d   = out_q;
    case (state_q)
      CAPTURE: begin
        a_d     = In1;
        b_d     = In2;
        acc_d   = '0;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // Full-width add: a row's upper limb overlaps the next row's
        // position, so carries must propagate across the whole accumulator.
        acc_d = acc_q + row_shifted;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(LIMBS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_d   = acc_q;
        state_d = CAPTURE;
      end
      default: begin
        state_d = CAPTURE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= CAPTURE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign Out         = out_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_parallel_mul.sv
module tb_parallel_mul;
  import pm_pkg::*;

  localparam int W      = 1024;
  localparam int SETTLE = 36;
  localparam int HOLD   = 40;
  localparam int NRAND  = 20;

  logic             clk;
  logic             rstn;
  logic [W-1:0]     in1, in2;
  logic [2*W-1:0]   out_w;
  logic [1:0]       dbg_state;

  parallel_mul dut (
    .clk         (clk),
    .rstn        (rstn),
    .In1         (in1),
    .In2         (in2),
    .Out         (out_w),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model and scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] exp_cur;   // product of the inputs currently applied
  logic [2*W-1:0] exp_prev;  // product Out may still show while settling
  int             since;     // cycles since last input change / reset release
  bit             run_cmp;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb;
    ea = {{W{1'b0}}, a};
    eb = {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  task automatic check(input string name, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got hi=%h lo=%h required hi=%h lo=%h", name,
               act[2*W-1 -: 128], act[127:0], exp[2*W-1 -: 128], exp[127:0]);
    end
  endtask

  // Every cycle: Out is 0 in reset, once settled it equals the current
  // product, and while settling it may only be the old or the new product.
  always @(negedge clk) begin
    if (run_cmp) begin
      if (!rstn) begin
        check("reset_out", out_w, '0);
      end else begin
        since++;
        if (since >= SETTLE) begin
          check("settled_out", out_w, exp_cur);
        end else begin
          tests++;
          if (out_w !== exp_cur && out_w !== exp_prev) begin
            fails++;
            $display("FAIL transient_out: got lo=%h allowed lo=%h or lo=%h",
                     out_w[127:0], exp_prev[127:0], exp_cur[127:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b);
    in1      = a;
    in2      = b;
    exp_prev = exp_cur;
    exp_cur  = ref_mul(a, b);
    since    = 0;
    exp_q.push_back(exp_cur);
  endtask

  task automatic release_reset();
    rstn     = 1'b1;
    exp_prev = '0;
    since    = 0;
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    for (int w = 0; w < W/32; w++) v[w*32 +: 32] = $urandom();
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = W'(v[63:0]);
      default: ;
    endcase
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [2*W-1:0] lit;
    logic [W-1:0]   a, b;
    bit             found;

    run_cmp  = 1'b0;
    rstn     = 1'b0;
    in1      = W'(44);
    in2      = W'(55);
    exp_cur  = ref_mul(W'(44), W'(55));
    exp_prev = '0;
    since    = 0;

    // Pin the model against hand-computed values.
    check("model_44x55", ref_mul(W'(44), W'(55)), (2*W)'(2420));
    check("model_4345x45345", ref_mul(W'(4345), W'(45345)), (2*W)'(197024025));

    run_cmp = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_hold_out", out_w, '0);
    release_reset();
    wait_cycles(SETTLE);
    check("after_reset_44x55", out_w, (2*W)'(2420));

    wait_cycles(1000 - SETTLE);
    apply(W'(44), W'(33));
    wait_cycles(SETTLE);
    check("change_44x33", out_w, (2*W)'(1452));

    apply(W'(4345), W'(45345));
    wait_cycles(SETTLE);
    check("multi_digit", out_w, (2*W)'(197024025));

    a = W'(64'hFFFF_FFFF_FFFF_FFFF);
    b = (W'(1) << 64) + W'(1);
    apply(a, b);
    wait_cycles(SETTLE);
    lit = ((2*W)'(1) << 128) - (2*W)'(1);
    check("carry_limbs", out_w, lit);

    apply('1, '1);
    wait_cycles(SETTLE);
    lit = '0;
    lit = lit - ((2*W)'(1) << 1025) + (2*W)'(1);
    check("max_operands", out_w, lit);

    apply('0, '1);
    wait_cycles(SETTLE);
    check("zero_operand", out_w, '0);

    // Asynchronous reset in the middle of a RUN phase.
    apply(W'(44), W'(55));
    wait_cycles(SETTLE);
    check("pre_reset_out", out_w, (2*W)'(2420));
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dbg_state == RUN) begin
        found = 1'b1;
        break;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL find_run: got state=%0d required state=%0d", dbg_state, RUN);
    end
    #1 rstn = 1'b0;
    #1 check("async_reset_out", out_w, '0);
    @(posedge clk);
    #2;
    release_reset();
    wait_cycles(SETTLE);
    check("after_midrun_reset", out_w, (2*W)'(2420));

    // Random operand pairs, each held for one window.
    exp_q.delete();
    for (int n = 0; n < NRAND; n++) begin
      a = rand_op();
      b = rand_op();
      apply(a, b);
      wait_cycles(HOLD);
      check("random_window", out_w, exp_q.pop_front());
    end

    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
